// File: rtl/mem_pkg.sv
// Shared load/store opcodes, FSM state encoding and opcode helpers.
// Imported by the ALU, decoder and the memory access unit.
package mem_pkg;

  localparam logic [4:0] OP_LWI = 5'b01110;
  localparam logic [4:0] OP_LW  = 5'b01111;
  localparam logic [4:0] OP_SWI = 5'b10000;
  localparam logic [4:0] OP_SW  = 5'b10001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FIN  = 2'd2
  } mem_state_e;

  function automatic logic is_store_op(input logic [4:0] op);
    return (op == OP_SWI) || (op == OP_SW);
  endfunction

  function automatic logic is_load_op(input logic [4:0] op);
    return (op == OP_LWI) || (op == OP_LW);
  endfunction

  function automatic logic is_mem_op(input logic [4:0] op);
    return is_load_op(op) || is_store_op(op);
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Saturating REQ-cycle counter; Expired flags the enabled cycle that
// completes TIMEOUT_CYCLES un-acked cycles. TIMEOUT_CYCLES=0 never expires.
// Ports: Clk, Reset_n (async low), Clear, Enable -> Expired.
module mem_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Clear,
  input  logic Enable,
  output logic Expired
);

  localparam int unsigned CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST =
    (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic TO_EN = (TIMEOUT_CYCLES != 0);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (Clear) begin
      cnt_d = '0;
    end else if (Enable && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q already holds the elapsed cycles, so this cycle is the last one
  assign Expired = TO_EN && Enable && (cnt_q >= LAST);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store memory access unit: one req/ack transaction per Start,
// Done/Error pulse on completion, LoadData holds the last good load.
// Ports: Clk, Reset_n, Start, Operation, ALUResult, StoreData,
//   MemReq/MemWE/MemAddr/MemWData/MemAck/MemRData, LoadData, Done,
//   Error, Busy. Optional macro MEM_ALIGN_CHECK_EN aborts misaligned
//   accesses without touching memory.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [4:0]        Operation,
  input  logic [ADDR_W-1:0] ALUResult,
  input  logic [ADDR_W-1:0] StoreData,
  output logic              MemReq,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [ADDR_W-1:0] MemWData,
  input  logic              MemAck,
  input  logic [ADDR_W-1:0] MemRData,
  output logic [ADDR_W-1:0] LoadData,
  output logic              Done,
  output logic              Error,
  output logic              Busy
);

  mem_state_e        state_q;
  logic              req_q;
  logic              we_q;
  logic              done_q;
  logic              err_q;
  logic              busy_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wdata_q;
  logic [ADDR_W-1:0] ldata_q;

  logic start_ok;
  logic misaligned;
  logic cnt_clr;
  logic cnt_en;
  logic expired;

  assign start_ok = Start && is_mem_op(Operation);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = |ALUResult[1:0];
`else
  assign misaligned = 1'b0;
`endif

  assign cnt_clr = (state_q == ST_IDLE) && start_ok;
  assign cnt_en  = (state_q == ST_REQ) && !MemAck;

  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .Clear  (cnt_clr),
    .Enable (cnt_en),
    .Expired(expired)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ldata_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            addr_q  <= ALUResult;
            wdata_q <= StoreData;
            we_q    <= is_store_op(Operation);
            busy_q  <= 1'b1;
            if (misaligned) begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= ST_REQ;
              req_q   <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          // an ack in the expiry cycle still completes normally
          if (MemAck) begin
            if (!we_q) begin
              ldata_q <= MemRData;
            end
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_FIN;
          end else if (expired) begin
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= ST_FIN;
          end
        end
        ST_FIN: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign MemReq   = req_q;
  assign MemWE    = we_q;
  assign MemAddr  = addr_q;
  assign MemWData = wdata_q;
  assign LoadData = ldata_q;
  assign Done     = done_q;
  assign Error    = err_q;
  assign Busy     = busy_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Consumer side of the ALU address path for the load/store opcodes LWI, LW, SWI and SW.
- Takes the ALU-computed effective address plus the store data and runs one request/acknowledge transaction on the data-memory port.
- Returns load data to register writeback and a one-cycle completion pulse to the control FSM.
- Sits between the main ALU/register file and data memory; one transaction in flight at a time.

Parameters:
- TIMEOUT_CYCLES, 255: maximum number of REQ-state cycles without MemAck before the transaction aborts. 0 disables the timeout.
- ADDR_W, 32: width of the address and data buses.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle request to begin a memory operation.
- Operation  input  5  opcode: 01110 LWI, 01111 LW, 10000 SWI, 10001 SW; all other codes are ignored.
- ALUResult  input  ADDR_W  effective address, sampled on Start.
- StoreData  input  ADDR_W  write data, sampled on Start for SWI/SW.
- MemReq  output  1  memory request, held until acknowledged.
- MemWE  output  1  1 = write, 0 = read; valid while MemReq is high.
- MemAddr  output  ADDR_W  latched address.
- MemWData  output  ADDR_W  latched store data.
- MemAck  input  1  memory acknowledge; MemRData is valid in the same cycle.
- MemRData  input  ADDR_W  read data.
- LoadData  output  ADDR_W  last successfully loaded word; holds until the next successful load.
- Done  output  1  one-cycle completion pulse.
- Error  output  1  qualifies Done; high only in the Done cycle of an aborted transaction.
- Busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, Reset_n=0): state IDLE. MemReq, MemWE, MemAddr, MemWData, LoadData, Done, Error, Busy and the timeout counter all go to 0 immediately, mid-transaction included. The in-flight access is abandoned and no Done is issued for it.
- States: IDLE, REQ, FIN.
- IDLE:
  - Start=1 with a valid load/store opcode: latch ALUResult into MemAddr and StoreData into MemWData. Set MemWE=1 for SWI/SW, 0 for LWI/LW. Clear the counter. Go to REQ.
  - Start=1 with any other opcode: no action. MemAck is ignored in IDLE.
- REQ:
  - MemReq=1. MemAddr, MemWE and MemWData stay stable.
  - On MemAck=1: for a load, LoadData <= MemRData. Go to FIN with Error=0.
  - Otherwise the counter increments. Once TIMEOUT_CYCLES cycles have elapsed without MemAck (TIMEOUT_CYCLES != 0): go to FIN with Error=1 and leave LoadData unchanged.
  - MemAck and timeout in the same cycle: MemAck wins.
- FIN: MemReq=0, Done=1 for exactly one cycle, Error as set on entry, then IDLE. Start is ignored in FIN; Busy is still 1.
- Latency:
  - Start in cycle 0 gives MemReq=1 from cycle 1.
  - If MemAck is high in cycle n (n>=1), Done is high in cycle n+1 with LoadData already valid.
  - Minimum Start-to-Done is 2 cycles.
- Start while Busy=1 is ignored; it is neither queued nor allowed to corrupt the latched values.
- Counter width: clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
- Done, Error, MemReq and MemWE are registered outputs with no combinational path from any input.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: Start with ALUResult[1:0] != 0 issues no memory request and goes directly IDLE->FIN, giving Done=1, Error=1 in cycle 1. MemReq never rises and LoadData is unchanged.
- Undefined: the address is passed through unmodified, including its low bits, and no alignment error is raised.

Decomposition:
- Shared package mem_pkg:
  - opcode constants OP_LWI=5'b01110, OP_LW=5'b01111, OP_SWI=5'b10000, OP_SW=5'b10001 (shared with the ALU and decoder);
  - state encoding constants for IDLE, REQ and FIN;
  - helper function is_mem_op(op).
- One sub-module, mem_timeout_counter:
  - parameterised by TIMEOUT_CYCLES;
  - inputs Clk, Reset_n, Clear, Enable;
  - output Expired.

Test Plan:
- Reset, then Start with LW, ALUResult=0x0000_0040, and memory acking in cycle 1 with MemRData=0xDEAD_BEEF -> MemReq cycle 1 only, MemWE=0, MemAddr=0x40, Done=1/Error=0 in cycle 2, LoadData=0xDEAD_BEEF held afterwards.
- SW with ALUResult=0x100, StoreData=0x1234_5678, MemAck delayed to cycle 5 -> MemReq=1 in cycles 1-5 with stable MemAddr/MemWData, MemWE=1, Done in cycle 6, LoadData unchanged.
- TIMEOUT_CYCLES=4, LWI with no MemAck -> MemReq high 4 cycles, then Done=1/Error=1; a later MemAck pulse in IDLE causes no change.
- Start with Operation=00010 (ADD) -> Busy stays 0, MemReq stays 0. Second Start issued while Busy -> ignored, MemAddr keeps its first value.
- Reset_n low during REQ -> MemReq and Busy drop without waiting for a clock edge, no Done. Next LW completes normally.
- With MEM_ALIGN_CHECK_EN defined, LW at 0x102 -> MemReq never rises, Done=1/Error=1 in cycle 1. With the macro undefined, the same stimulus reaches memory with MemAddr=0x102.
